// File: rtl/display_arbiter.sv
// Fixed-priority, hold-protected owner arbiter for the 8-digit display driver.
// Optional blink gating is enabled with `define DISPLAY_BLINK_EN.
module display_arbiter #(
  parameter int CLK_PER_MS = 100000,
  parameter int HOLD_MS    = 250,
  parameter int BLINK_MS   = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [47:0] frame0,
  input  logic [47:0] frame1,
  input  logic [47:0] frame2,
  input  logic [2:0]  blink,
  output logic [2:0]  gnt,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8
);

  localparam int MW = $clog2(CLK_PER_MS + 1);
  localparam int HW = $clog2(HOLD_MS + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    gnt_nxt;
  logic [MW-1:0] ms_cnt;
  logic          ms_tick;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          hold_ok;
  logic [47:0]   frame_sel;
  logic [47:0]   frame_out;
  logic          dim;

  function automatic logic [2:0] pick(input logic [2:0] r);
    logic [2:0] g;
    g = 3'b000;
    if (r[0])      g = 3'b001;
    else if (r[1]) g = 3'b010;
    else if (r[2]) g = 3'b100;
    return g;
  endfunction

  assign ms_tick = (ms_cnt == MW'(CLK_PER_MS - 1));
  assign hold_ok = (hold_cnt == HW'(HOLD_MS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ms_cnt <= '0;
    else if (ms_tick) ms_cnt <= '0;
    else ms_cnt <= ms_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    hold_nxt  = hold_cnt;
    if (ms_tick && !hold_ok) hold_nxt = hold_cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          gnt_nxt   = pick(req);
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (~|(req & gnt)) begin
          hold_nxt = '0;
          gnt_nxt  = pick(req);
          if (~|req) state_nxt = IDLE;
        end else if (|(req & (gnt - 3'd1)) && hold_ok) begin
          // one-hot minus one masks exactly the higher-priority clients
          gnt_nxt  = pick(req);
          hold_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 3'b000;
        hold_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    frame_sel = '0;
    case (1'b1)
      gnt[0]:  frame_sel = frame0;
      gnt[1]:  frame_sel = frame1;
      gnt[2]:  frame_sel = frame2;
      default: frame_sel = '0;
    endcase
  end

`ifdef DISPLAY_BLINK_EN
  localparam int BW = $clog2(BLINK_MS + 1);

  logic          phase;
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase     <= 1'b1;
      blink_cnt <= '0;
    end else if (gnt_nxt != gnt) begin
      phase     <= 1'b1;
      blink_cnt <= '0;
    end else if (ms_tick) begin
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign dim = (|(blink & gnt)) & ~phase;
`else
  logic unused_blink;
  assign unused_blink = ^blink;
  assign dim = 1'b0;
`endif

  always_comb begin
    frame_out = frame_sel;
    if (dim)
      for (int i = 0; i < 8; i++) frame_out[6*i+5] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) {d1, d2, d3, d4, d5, d6, d7, d8} <= '0;
    else {d1, d2, d3, d4, d5, d6, d7, d8} <= frame_out;
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (CLK_PER_MS=10, HOLD_MS=3, BLINK_MS=2).
// Build with +define+DISPLAY_BLINK_EN to exercise the blink path.
module tb_display_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  req;
  logic [47:0] frame0, frame1, frame2;
  logic [2:0]  blink;
  logic [2:0]  gnt;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;

  int n_tot = 0;
  int n_bad = 0;

  display_arbiter #(
    .CLK_PER_MS(10),
    .HOLD_MS(3),
    .BLINK_MS(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .frame0(frame0),
    .frame1(frame1),
    .frame2(frame2),
    .blink(blink),
    .gnt(gnt),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .d5(d5), .d6(d6), .d7(d7), .d8(d8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int t;
    int cnt;
    bit done;
    logic [47:0] dall;
    logic prev;
    int run_len, runs, bad_runs, low_bad;
    bit started, saw0, saw1;

    reset  = 1'b0;
    req    = 3'b000;
    blink  = 3'b000;
    frame0 = 48'h0;
    frame1 = 48'h0;
    frame2 = 48'h0;
    #2;
    chk("rst_gnt", 48'(gnt), 48'h0);
    chk("rst_d1", 48'(d1), 48'h0);
    step(2);
    reset = 1'b1;
    step(2);
    chk("idle_gnt", 48'(gnt), 48'h0);

    // single client
    frame2 = {48{1'b1}};
    req = 3'b100;
    step(1);
    chk("single_gnt", 48'(gnt), 48'h4);
    chk("single_dlag", 48'(d1), 48'h0);
    step(1);
    chk("single_d1", 48'(d1), 48'h3F);
    chk("single_d8", 48'(d8), 48'h3F);
    req = 3'b000;
    step(1);
    chk("drop_gnt", 48'(gnt), 48'h0);
    step(1);
    chk("drop_d", {d1, d2, d3, d4, d5, d6, d7, d8}, 48'h0);

    // simultaneous
    frame0 = 48'h9A5_3C1_7E2_B44;
    frame1 = 48'h123_456_789_ABC;
    req = 3'b111;
    step(1);
    chk("sim_gnt", 48'(gnt), 48'h1);
    step(1);
    chk("sim_d1", 48'(d1), 48'(frame0[47:42]));
    chk("sim_d8", 48'(d8), 48'(frame0[5:0]));
    req = 3'b110;
    step(1);
    chk("rel_next", 48'(gnt), 48'h2);
    step(1);
    chk("rel_d", {d1, d2, d3, d4, d5, d6, d7, d8}, frame1);
    req = 3'b000;
    step(2);
    chk("sim_idle", 48'(gnt), 48'h0);

    // hold before preemption
    req = 3'b100;
    step(1);
    chk("hold_gnt2", 48'(gnt), 48'h4);
    t = 0;
    step(5);
    t = 5;
    req = 3'b101;
    cnt = 0;
    while (t < 20) begin
      step(1);
      t++;
      if (gnt !== 3'b100) cnt++;
    end
    chk("hold_keep", 48'(cnt), 48'h0);
    done = 1'b0;
    while (!done && t < 40) begin
      step(1);
      t++;
      if (gnt === 3'b001) done = 1'b1;
    end
    chk("hold_pre", 48'(gnt), 48'h1);
    chk("hold_lat", 48'(t >= 21 && t <= 31), 48'h1);

    // async reset mid-grant
    step(1);
    chk("pre_rst_d1", 48'(d1), 48'(frame0[47:42]));
    #1 reset = 1'b0;
    #1;
    chk("arst_gnt", 48'(gnt), 48'h0);
    chk("arst_d", {d1, d2, d3, d4, d5, d6, d7, d8}, 48'h0);
    req = 3'b000;
    step(1);
    reset = 1'b1;
    step(2);
    chk("arst_idle", 48'(gnt), 48'h0);

    // lower priority never preempts
    req = 3'b001;
    step(1);
    chk("lp_gnt", 48'(gnt), 48'h1);
    req = 3'b101;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (gnt !== 3'b001) cnt++;
    end
    chk("lp_keep", 48'(cnt), 48'h0);
    req = 3'b000;
    step(2);

    // blink path
    for (int i = 0; i < 8; i++)
      frame1[6*i +: 6] = {1'b1, 4'(i + 3), 1'(i)};
    blink = 3'b010;
    req = 3'b010;
    step(1);
    chk("bl_gnt", 48'(gnt), 48'h2);
    step(1);
    low_bad = 0;
    runs = 0;
    bad_runs = 0;
    run_len = 0;
    started = 1'b0;
    saw0 = 1'b0;
    saw1 = 1'b0;
    prev = d1[5];
    for (int i = 0; i < 100; i++) begin
      dall = {d1, d2, d3, d4, d5, d6, d7, d8};
      for (int k = 0; k < 8; k++) begin
        if (dall[6*k +: 5] !== frame1[6*k +: 5]) low_bad++;
        if (dall[6*k+5] !== d1[5]) low_bad++;
      end
      if (d1[5]) saw1 = 1'b1;
      else saw0 = 1'b1;
      if (d1[5] !== prev) begin
        if (started) begin
          runs++;
          if (run_len != 20) bad_runs++;
        end
        started = 1'b1;
        run_len = 0;
      end
      run_len++;
      prev = d1[5];
      step(1);
    end
    chk("bl_low", 48'(low_bad), 48'h0);
    chk("bl_on", 48'(saw1), 48'h1);
`ifdef DISPLAY_BLINK_EN
    chk("bl_off", 48'(saw0), 48'h1);
    chk("bl_runs", 48'(runs >= 2), 48'h1);
    chk("bl_len", 48'(bad_runs), 48'h0);
`else
    chk("bl_const", 48'(saw0), 48'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
